// File: rtl/cpu_pkg.sv
// Shared widths and load-op encoding for the CPU pipeline stages.
package cpu_pkg;

    localparam int RF_BUS_W  = 38;
    localparam int CSR_BUS_W = 109;
    localparam int EXC_BUS_W = 6;
    localparam int FWD_BUS_W = 40;

    // Bit positions in the one-hot load op {ld_b, ld_h, ld_w, ld_bu, ld_hu}
    localparam int LD_B  = 4;
    localparam int LD_H  = 3;
    localparam int LD_W  = 2;
    localparam int LD_BU = 1;
    localparam int LD_HU = 0;

    typedef logic [RF_BUS_W-1:0] rf_bus_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the byte/half addressed by addr[1:0] and extends it.
module mem_load_align
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [4:0]  mem_op,
    output logic [31:0] wdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wdata = rdata;
        if (mem_op[LD_B])
            wdata = {{24{byte_sel[7]}}, byte_sel};
        else if (mem_op[LD_BU])
            wdata = {24'd0, byte_sel};
        else if (mem_op[LD_H])
            wdata = {{16{half_sel[15]}}, half_sel};
        else if (mem_op[LD_HU])
            wdata = {16'd0, half_sel};
        else if (mem_op[LD_W])
            wdata = rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-bus response, aligns load data, forwards to ID.
// Optional macro MEM_LOAD_FWD_EN: release load_pending to ID in the cycle the load data arrives.
module mem_stage
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ex_to_mem_valid,
    output logic                 mem_allowin,
    input  logic [31:0]          ex_pc,
    input  logic [RF_BUS_W-1:0]  ex_rf_all,
    input  logic [4:0]           ex_mem_op,
    input  logic                 ex_req_issued,
    input  logic [CSR_BUS_W-1:0] ex_csr_rf,
    input  logic [EXC_BUS_W-1:0] ex_exc_rf,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 cancel_exc_ertn,
    input  logic                 wb_allowin,
    output logic                 mem_to_wb_valid,
    output logic [31:0]          mem_pc,
    output logic [RF_BUS_W-1:0]  mem_rf_all,
    output logic [CSR_BUS_W-1:0] mem_csr_rf,
    output logic [EXC_BUS_W-1:0] mem_exc_rf,
    output logic [FWD_BUS_W-1:0] mem_fwd,
    output logic                 mem_exc_block
);

    logic                 mem_valid;
    logic [31:0]          pc_q;
    rf_bus_t              rf_q;
    logic [4:0]           op_q;
    logic [CSR_BUS_W-1:0] csr_q;
    logic [EXC_BUS_W-1:0] exc_q;
    logic                 req_pending;
    logic [1:0]           discard_cnt;
    logic [31:0]          rdata_buf;
    logic                 buf_valid;

    logic        owned_ok;
    logic        discard_ok;
    logic        disc_inc;
    logic        ready_go;
    logic        accept;
    logic        leave;
    logic        is_load;
    logic        load_pending;
    logic [31:0] load_data;
    logic [31:0] load_wdata;
    logic [31:0] final_wdata;

    assign discard_ok = data_sram_data_ok & (discard_cnt != 2'd0);
    assign owned_ok   = data_sram_data_ok & (discard_cnt == 2'd0) & req_pending;
    // A flush that lands on the owned response consumes it, so nothing is owed afterwards.
    assign disc_inc   = cancel_exc_ertn & mem_valid & req_pending & ~owned_ok;

    assign ready_go        = ~req_pending | buf_valid | owned_ok;
    assign mem_to_wb_valid = mem_valid & ready_go;
    assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
    assign accept          = ex_to_mem_valid & mem_allowin;
    assign leave           = mem_to_wb_valid & wb_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
        end else if (cancel_exc_ertn) begin
            mem_valid <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid <= ex_to_mem_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q  <= 32'd0;
            rf_q  <= '0;
            op_q  <= 5'd0;
            csr_q <= '0;
            exc_q <= '0;
        end else if (accept) begin
            pc_q  <= ex_pc;
            rf_q  <= ex_rf_all;
            op_q  <= ex_mem_op;
            csr_q <= ex_csr_rf;
            exc_q <= ex_exc_rf;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || cancel_exc_ertn) begin
            req_pending <= 1'b0;
        end else if (mem_allowin) begin
            req_pending <= ex_to_mem_valid & ex_req_issued;
        end else if (owned_ok) begin
            req_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            discard_cnt <= 2'd0;
        end else if (disc_inc && !discard_ok) begin
            if (discard_cnt != 2'd3)
                discard_cnt <= discard_cnt + 2'd1;
        end else if (discard_ok && !disc_inc) begin
            discard_cnt <= discard_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            rdata_buf <= 32'd0;
        end else begin
            if (cancel_exc_ertn || leave)
                buf_valid <= 1'b0;
            else if (owned_ok)
                buf_valid <= 1'b1;
            if (owned_ok)
                rdata_buf <= data_sram_rdata;
        end
    end

    assign is_load   = |op_q;
    assign load_data = buf_valid ? rdata_buf : data_sram_rdata;

    mem_load_align u_align (
        .rdata  (load_data),
        .addr   (rf_q[1:0]),
        .mem_op (op_q),
        .wdata  (load_wdata)
    );

    assign final_wdata = is_load ? load_wdata : rf_q[31:0];

`ifdef MEM_LOAD_FWD_EN
    assign load_pending = mem_valid & is_load & ~(buf_valid | owned_ok);
`else
    assign load_pending = mem_valid & is_load;
`endif

    assign mem_pc        = pc_q;
    assign mem_rf_all    = {rf_q[37:32], final_wdata};
    assign mem_csr_rf    = csr_q;
    assign mem_exc_rf    = exc_q;
    assign mem_fwd       = {mem_valid, rf_q[37], rf_q[36:32], load_pending, final_wdata};
    assign mem_exc_block = mem_valid & (|exc_q);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/ALU ops, late/held responses, flush discard.
module tb_mem_stage;
    import cpu_pkg::*;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 ex_to_mem_valid;
    logic                 mem_allowin;
    logic [31:0]          ex_pc;
    logic [RF_BUS_W-1:0]  ex_rf_all;
    logic [4:0]           ex_mem_op;
    logic                 ex_req_issued;
    logic [CSR_BUS_W-1:0] ex_csr_rf;
    logic [EXC_BUS_W-1:0] ex_exc_rf;
    logic                 data_sram_data_ok;
    logic [31:0]          data_sram_rdata;
    logic                 cancel_exc_ertn;
    logic                 wb_allowin;
    logic                 mem_to_wb_valid;
    logic [31:0]          mem_pc;
    logic [RF_BUS_W-1:0]  mem_rf_all;
    logic [CSR_BUS_W-1:0] mem_csr_rf;
    logic [EXC_BUS_W-1:0] mem_exc_rf;
    logic [FWD_BUS_W-1:0] mem_fwd;
    logic                 mem_exc_block;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ex_to_mem_valid   (ex_to_mem_valid),
        .mem_allowin       (mem_allowin),
        .ex_pc             (ex_pc),
        .ex_rf_all         (ex_rf_all),
        .ex_mem_op         (ex_mem_op),
        .ex_req_issued     (ex_req_issued),
        .ex_csr_rf         (ex_csr_rf),
        .ex_exc_rf         (ex_exc_rf),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .cancel_exc_ertn   (cancel_exc_ertn),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_pc            (mem_pc),
        .mem_rf_all        (mem_rf_all),
        .mem_csr_rf        (mem_csr_rf),
        .mem_exc_rf        (mem_exc_rf),
        .mem_fwd           (mem_fwd),
        .mem_exc_block     (mem_exc_block)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] OP_B  = 5'b10000;
    localparam logic [4:0] OP_H  = 5'b01000;
    localparam logic [4:0] OP_W  = 5'b00100;
    localparam logic [4:0] OP_BU = 5'b00010;
    localparam logic [4:0] OP_HU = 5'b00001;

`ifdef MEM_LOAD_FWD_EN
    localparam logic LP_ON_OK = 1'b0;
`else
    localparam logic LP_ON_OK = 1'b1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    logic [69:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every WB handshake pops one expected {pc, rf_all}.
    always @(negedge clk) begin
        if (resetn && mem_to_wb_valid && wb_allowin) begin
            logic [69:0] e;
            pulses++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wb_unexpected: got pc %h rf %h expected no output", mem_pc, mem_rf_all);
            end else begin
                e = exp_q.pop_front();
                if ({mem_pc, mem_rf_all} !== e) begin
                    n_bad++;
                    $display("FAIL wb_out: got pc %h rf %h expected pc %h rf %h",
                             mem_pc, mem_rf_all, e[69:38], e[37:0]);
                end
            end
        end
    end

    task automatic send(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                        input logic [31:0] res, input logic [4:0] op, input logic req,
                        input logic [5:0] exc, input logic [31:0] exp_wdata, input logic expect_out);
        int n;
        ex_pc           = pc;
        ex_rf_all       = {we, wa, res};
        ex_mem_op       = op;
        ex_req_issued   = req;
        ex_exc_rf       = exc;
        ex_csr_rf       = {pc, pc, pc, 13'h1abc};
        ex_to_mem_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!mem_allowin && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mem_allowin) chk("accept_timeout", 64'(mem_allowin), 64'd1);
        if (expect_out) exp_q.push_back({pc, we, wa, exp_wdata});
        step();
        ex_to_mem_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        resetn = 1'b0; ex_to_mem_valid = 1'b0; ex_pc = '0; ex_rf_all = '0; ex_mem_op = '0;
        ex_req_issued = 1'b0; ex_csr_rf = '0; ex_exc_rf = '0; data_sram_data_ok = 1'b0;
        data_sram_rdata = '0; cancel_exc_ertn = 1'b0; wb_allowin = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", 64'(mem_to_wb_valid), 64'd0);
        chk("rst_exc_block", 64'(mem_exc_block), 64'd0);
        chk("rst_fwd", 64'(mem_fwd[39:32]), 64'd0);
        chk("rst_rf", 64'(mem_rf_all), 64'd0);
        chk("rst_pc", 64'(mem_pc), 64'd0);
        step();
        resetn = 1'b1;
        step();

        // add r5: one cycle in MEM, forwarded immediately
        send(32'h100, 1'b1, 5'd5, 32'h1234, 5'd0, 1'b0, 6'd0, 32'h1234, 1'b1);
        @(negedge clk);
        chk("add_fwd", 64'(mem_fwd), {24'd0, 1'b1, 1'b1, 5'd5, 1'b0, 32'h1234});
        chk("add_valid", 64'(mem_to_wb_valid), 64'd1);
        chk("add_csr", 64'(mem_csr_rf[63:0]), {32'h100, 32'h100} << 13 | 64'h1abc);
        step();

        // ld_b at offset 2 -> sign-extended 0x80
        send(32'h104, 1'b1, 5'd6, 32'h1002, OP_B, 1'b1, 6'd0, 32'hFFFFFF80, 1'b1);
        @(negedge clk);
        chk("ldb_wait_allowin", 64'(mem_allowin), 64'd0);
        chk("ldb_wait_lp", 64'(mem_fwd[32]), 64'd1);
        step();
        respond(32'h12803456);
        @(negedge clk);
        chk("ldb_ok_lp", 64'(mem_fwd[32]), 64'(LP_ON_OK));
        step();
        data_sram_data_ok = 1'b0;

        send(32'h108, 1'b1, 5'd7, 32'h1002, OP_BU, 1'b1, 6'd0, 32'h00000080, 1'b1);
        step();
        respond(32'h12803456);
        step();
        data_sram_data_ok = 1'b0;

        send(32'h10c, 1'b1, 5'd8, 32'h2002, OP_H, 1'b1, 6'd0, 32'hFFFF8001, 1'b1);
        step();
        respond(32'h80017FFF);
        step();
        data_sram_data_ok = 1'b0;

        // data_ok three cycles late: exactly one WB pulse
        p0 = pulses;
        send(32'h110, 1'b1, 5'd9, 32'h3000, OP_W, 1'b1, 6'd0, 32'hA5A51234, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_allowin", 64'(mem_allowin), 64'd0);
            step();
        end
        respond(32'hA5A51234);
        @(negedge clk);
        chk("late_allowin_ok", 64'(mem_allowin), 64'd1);
        step();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("late_after_valid", 64'(mem_to_wb_valid), 64'd0);
        chk("late_pulses", 64'(pulses - p0), 64'd1);
        step();

        // response while WB stalled: buffered, delivered two cycles later
        wb_allowin = 1'b0;
        send(32'h114, 1'b1, 5'd10, 32'h4000, OP_HU, 1'b1, 6'd0, 32'h0000ABCD, 1'b1);
        respond(32'h1234ABCD);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEADBEEF;
        @(negedge clk);
        chk("buf_valid_out", 64'(mem_to_wb_valid), 64'd1);
        chk("buf_allowin", 64'(mem_allowin), 64'd0);
        step();
        wb_allowin = 1'b1;
        step();

        // flush with a load outstanding: first response discarded
        send(32'h200, 1'b1, 5'd11, 32'h5000, OP_W, 1'b1, 6'd0, 32'd0, 1'b0);
        cancel_exc_ertn = 1'b1;
        step();
        cancel_exc_ertn = 1'b0;
        send(32'h204, 1'b1, 5'd12, 32'h5004, OP_W, 1'b1, 6'd0, 32'hCAFEF00D, 1'b1);
        respond(32'h11111111);
        @(negedge clk);
        chk("flush_discard_allowin", 64'(mem_allowin), 64'd0);
        chk("flush_discard_valid", 64'(mem_to_wb_valid), 64'd0);
        step();
        respond(32'hCAFEF00D);
        step();
        data_sram_data_ok = 1'b0;

        // exception bus sets exc_block
        wb_allowin = 1'b0;
        send(32'h300, 1'b0, 5'd0, 32'h77, 5'd0, 1'b0, 6'b000010, 32'h77, 1'b1);
        @(negedge clk);
        chk("exc_block", 64'(mem_exc_block), 64'd1);
        chk("exc_bus", 64'(mem_exc_rf), 64'b000010);
        step();
        wb_allowin = 1'b1;
        repeat (3) step();

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
